// File: rtl/miriscv_data_bus_pkg.sv
// Shared definitions for the miriscv data-bus interconnect: FSM encoding,
// the default slave map and the error-counter width.
package miriscv_data_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_e;

  localparam int ERR_CNT_W = 8;

  // Default map: slave0 RAM at 0, slave1 timers at 0x8000_0000, slave2 GPIO at 0x8000_0100
  localparam int              DEF_N_SLV    = 3;
  localparam logic [3*32-1:0] DEF_SLV_BASE = {32'h8000_0100, 32'h8000_0000, 32'h0000_0000};
  localparam logic [3*32-1:0] DEF_SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000};
  localparam int              DEF_TIMEOUT  = 16;

  // Slave index width; a single-slave bus still carries a 1-bit index
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miriscv_data_bus_if.sv
// LSU-side and slave-side signals of the data bus. The master modport is the
// environment (core LSU plus slaves); the slave modport is the interconnect itself.
interface miriscv_data_bus_if #(
  parameter int N_SLV = 3
);

  logic                  lsu_req;
  logic                  lsu_we;
  logic [3:0]            lsu_be;
  logic [31:0]           lsu_addr;
  logic [31:0]           lsu_wdata;
  logic [31:0]           lsu_rdata;
  logic                  lsu_stall;

  logic [N_SLV-1:0]      slv_req;
  logic                  slv_we;
  logic [3:0]            slv_be;
  logic [31:0]           slv_addr;
  logic [31:0]           slv_wdata;
  logic [N_SLV*32-1:0]   slv_rdata;
  logic [N_SLV-1:0]      slv_ack;

  logic                  bus_err;
  logic [31:0]           err_addr;
  logic [miriscv_data_bus_pkg::ERR_CNT_W-1:0] err_cnt;

  modport master (
    output lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata, slv_rdata, slv_ack,
    input  lsu_rdata, lsu_stall, slv_req, slv_we, slv_be, slv_addr, slv_wdata,
           bus_err, err_addr, err_cnt
  );

  modport slave (
    input  lsu_req, lsu_we, lsu_be, lsu_addr, lsu_wdata, slv_rdata, slv_ack,
    output lsu_rdata, lsu_stall, slv_req, slv_we, slv_be, slv_addr, slv_wdata,
           bus_err, err_addr, err_cnt
  );

endinterface

// File: rtl/miriscv_data_bus_addr_decoder.sv
// Combinational priority address decoder; on overlapping windows the lowest
// slave index wins.
module miriscv_data_bus_addr_decoder
  import miriscv_data_bus_pkg::*;
#(
  parameter int N_SLV = 3,
  parameter int IDX_W = idx_width(N_SLV)
) (
  input  logic [31:0]         addr,
  input  logic [N_SLV*32-1:0] base,
  input  logic [N_SLV*32-1:0] mask,
  output logic                hit,
  output logic [IDX_W-1:0]    idx
);

  // Scan from the top so the lowest matching index is written last
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & mask[i*32 +: 32]) == base[i*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/miriscv_data_bus.sv
// Data-bus interconnect between the core LSU and N_SLV memory-mapped slaves,
// with stall handshake, ack timeout and bus-error reporting.
//
//   state | meaning
//   IDLE  | waiting for an LSU request; stall follows the request
//   BUSY  | request presented to the selected slave, waiting for its ack
//   DONE  | access complete; stall released for one cycle so the core retires
//   ERR   | decode miss or timeout; bus_err pulse, read data forced to 0
module miriscv_data_bus
  import miriscv_data_bus_pkg::*;
#(
  parameter int                  N_SLV    = DEF_N_SLV,
  parameter logic [N_SLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*32-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int                  TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  miriscv_data_bus_if.slave bus
);

  localparam int IDX_W = idx_width(N_SLV);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_e               state_q, state_nxt;
  logic [IDX_W-1:0]         idx_q, dec_idx;
  logic                     dec_hit;
  logic                     we_q;
  logic [3:0]               be_q;
  logic [31:0]              addr_q, wdata_q, rdata_q, err_addr_q;
  logic [ERR_CNT_W-1:0]     err_cnt_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sel_ack;
  logic [31:0]              sel_rdata;
  logic                     stall;
  logic                     bus_err;
  logic [N_SLV-1:0]         slv_req;

  miriscv_data_bus_addr_decoder #(
    .N_SLV (N_SLV),
    .IDX_W (IDX_W)
  ) u_addr_decoder (
    .addr  (bus.lsu_addr),
    .base  (SLV_BASE),
    .mask  (SLV_MASK),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  // Only the latched slave's ack and data are ever looked at
  assign sel_ack   = bus.slv_ack[idx_q];
  assign sel_rdata = bus.slv_rdata[int'(idx_q)*32 +: 32];

  always_comb begin
    state_nxt = state_q;
    stall     = 1'b0;
    bus_err   = 1'b0;
    slv_req   = '0;
    case (state_q)
      ST_IDLE: begin
        stall = bus.lsu_req;
        if (bus.lsu_req) begin
          state_nxt = dec_hit ? ST_BUSY : ST_ERR;
        end
      end
      ST_BUSY: begin
        stall          = 1'b1;
        slv_req[idx_q] = 1'b1;
        if (sel_ack) begin
          state_nxt = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        bus_err   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_IDLE && bus.lsu_req) begin
        we_q    <= bus.lsu_we;
        be_q    <= bus.lsu_be;
        addr_q  <= bus.lsu_addr;
        wdata_q <= bus.lsu_wdata;
        idx_q   <= dec_idx;
      end
      // BUSY is only entered from IDLE, so holding the counter clear there restarts it
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == ST_BUSY && sel_ack && !we_q) begin
        rdata_q <= sel_rdata;
      end
      // A decode miss enters ERR in the same edge that latches the address
      if (state_nxt == ST_ERR) begin
        rdata_q    <= '0;
        err_addr_q <= (state_q == ST_IDLE) ? bus.lsu_addr : addr_q;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.lsu_stall = stall;
  assign bus.lsu_rdata = rdata_q;
  assign bus.slv_req   = slv_req;
  assign bus.slv_we    = we_q;
  assign bus.slv_be    = be_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;
  assign bus.bus_err   = bus_err;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Directed bench for miriscv_data_bus: default map on dut_a, overlapping map
// on dut_b to exercise decode priority and foreign-ack rejection.
module tb_miriscv_data_bus;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  miriscv_data_bus_if #(.N_SLV(3)) bus_a ();
  miriscv_data_bus_if #(.N_SLV(3)) bus_b ();

  miriscv_data_bus #(
    .N_SLV    (3),
    .SLV_BASE ({32'h8000_0100, 32'h8000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000}),
    .TIMEOUT  (16)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  // slave1 has an all-zero mask and base, so it matches every address
  miriscv_data_bus #(
    .N_SLV    (3),
    .SLV_BASE ({32'h8000_0100, 32'h0000_0000, 32'h8000_0000}),
    .SLV_MASK ({32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00}),
    .TIMEOUT  (16)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic lsu_a(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus_a.lsu_req   = req;
    bus_a.lsu_we    = we;
    bus_a.lsu_be    = be;
    bus_a.lsu_addr  = addr;
    bus_a.lsu_wdata = wdata;
  endtask

  task automatic lsu_b(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus_b.lsu_req   = req;
    bus_b.lsu_we    = we;
    bus_b.lsu_be    = be;
    bus_b.lsu_addr  = addr;
    bus_b.lsu_wdata = wdata;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_stall"},    32'(bus_a.lsu_stall), 32'd0);
    check({tag, "_slv_req"},  32'(bus_a.slv_req),   32'd0);
    check({tag, "_slv_we"},   32'(bus_a.slv_we),    32'd0);
    check({tag, "_slv_be"},   32'(bus_a.slv_be),    32'd0);
    check({tag, "_slv_addr"}, bus_a.slv_addr,       32'd0);
    check({tag, "_slv_wdata"},bus_a.slv_wdata,      32'd0);
    check({tag, "_rdata"},    bus_a.lsu_rdata,      32'd0);
    check({tag, "_bus_err"},  32'(bus_a.bus_err),   32'd0);
    check({tag, "_err_addr"}, bus_a.err_addr,       32'd0);
    check({tag, "_err_cnt"},  32'(bus_a.err_cnt),   32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    lsu_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus_a.slv_ack   = '0;
    bus_a.slv_rdata = '0;
    bus_b.slv_ack   = '0;
    bus_b.slv_rdata = '0;
    repeat (3) step();
    check_a_zero("rst");
    reset = 1'b0;
    step();

    // 1: read slave0, ack in first BUSY cycle
    lsu_a(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    #1 check("t1_idle_stall", 32'(bus_a.lsu_stall), 32'd1);
    step();
    check("t1_busy_req",   32'(bus_a.slv_req),   32'b001);
    check("t1_busy_stall", 32'(bus_a.lsu_stall), 32'd1);
    check("t1_slv_addr",   bus_a.slv_addr,       32'h0000_0010);
    bus_a.slv_ack   = 3'b001;
    bus_a.slv_rdata = {32'h0, 32'h0, 32'hDEAD_BEEF};
    step();
    bus_a.slv_ack = '0;
    check("t1_done_stall", 32'(bus_a.lsu_stall), 32'd0);
    check("t1_done_rdata", bus_a.lsu_rdata,      32'hDEAD_BEEF);
    check("t1_done_req",   32'(bus_a.slv_req),   32'd0);
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("t1_idle_stall0", 32'(bus_a.lsu_stall), 32'd0);

    // 2: write slave2, ack after 5 BUSY cycles; LSU inputs scrambled after latch
    lsu_a(1'b1, 1'b1, 4'b0001, 32'h8000_0104, 32'h0000_0055);
    bus_a.slv_rdata = {32'h5A5A_5A5A, 32'h0, 32'h0};
    #1 check("t2_idle_stall", 32'(bus_a.lsu_stall), 32'd1);
    step();
    bus_a.lsu_addr  = 32'h0000_0000;
    bus_a.lsu_wdata = 32'hFFFF_FFFF;
    bus_a.lsu_be    = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      check("t2_busy_req",   32'(bus_a.slv_req),   32'b100);
      check("t2_busy_stall", 32'(bus_a.lsu_stall), 32'd1);
      check("t2_slv_we",     32'(bus_a.slv_we),    32'd1);
      check("t2_slv_be",     32'(bus_a.slv_be),    32'b0001);
      check("t2_slv_addr",   bus_a.slv_addr,       32'h8000_0104);
      check("t2_slv_wdata",  bus_a.slv_wdata,      32'h0000_0055);
      if (k == 5) bus_a.slv_ack = 3'b100;
      step();
    end
    bus_a.slv_ack = '0;
    check("t2_done_stall", 32'(bus_a.lsu_stall), 32'd0);
    check("t2_done_rdata", bus_a.lsu_rdata,      32'hDEAD_BEEF);
    check("t2_done_err",   32'(bus_a.bus_err),   32'd0);
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    // 3: unmapped read
    lsu_a(1'b1, 1'b0, 4'hF, 32'h4000_0000, 32'h0);
    #1 check("t3_idle_stall", 32'(bus_a.lsu_stall), 32'd1);
    step();
    check("t3_bus_err",  32'(bus_a.bus_err),   32'd1);
    check("t3_stall",    32'(bus_a.lsu_stall), 32'd0);
    check("t3_rdata",    bus_a.lsu_rdata,      32'd0);
    check("t3_err_addr", bus_a.err_addr,       32'h4000_0000);
    check("t3_err_cnt",  32'(bus_a.err_cnt),   32'd1);
    check("t3_slv_req",  32'(bus_a.slv_req),   32'd0);
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("t3_err_pulse", 32'(bus_a.bus_err), 32'd0);

    // 4a: slave1 never acks -> ERR after exactly 16 BUSY cycles
    lsu_a(1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
    step();
    for (int k = 1; k <= 16; k++) begin
      check("t4a_busy_req", 32'(bus_a.slv_req),   32'b010);
      check("t4a_busy_err", 32'(bus_a.bus_err),   32'd0);
      check("t4a_stall",    32'(bus_a.lsu_stall), 32'd1);
      step();
    end
    check("t4a_bus_err",  32'(bus_a.bus_err),   32'd1);
    check("t4a_stall0",   32'(bus_a.lsu_stall), 32'd0);
    check("t4a_err_cnt",  32'(bus_a.err_cnt),   32'd2);
    check("t4a_err_addr", bus_a.err_addr,       32'h8000_0000);
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    // 4b: ack on the 16th BUSY cycle beats the timeout
    lsu_a(1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
    bus_a.slv_rdata = {32'h0, 32'hCAFE_0016, 32'h0};
    step();
    for (int k = 1; k <= 16; k++) begin
      check("t4b_busy_req", 32'(bus_a.slv_req), 32'b010);
      if (k == 16) bus_a.slv_ack = 3'b010;
      step();
    end
    bus_a.slv_ack = '0;
    check("t4b_bus_err", 32'(bus_a.bus_err),   32'd0);
    check("t4b_stall",   32'(bus_a.lsu_stall), 32'd0);
    check("t4b_rdata",   bus_a.lsu_rdata,      32'hCAFE_0016);
    check("t4b_err_cnt", 32'(bus_a.err_cnt),   32'd2);
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("t4b_idle_err", 32'(bus_a.bus_err), 32'd0);

    // 5: overlapping map, lowest index wins; foreign acks ignored
    lsu_b(1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
    step();
    check("t5_prio_req0", 32'(bus_b.slv_req), 32'b001);
    bus_b.slv_ack   = 3'b001;
    bus_b.slv_rdata = {32'h0, 32'h0, 32'h1111_1111};
    step();
    bus_b.slv_ack = '0;
    check("t5_rdata0", bus_b.lsu_rdata, 32'h1111_1111);
    lsu_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    lsu_b(1'b1, 1'b0, 4'hF, 32'h0000_1234, 32'h0);
    step();
    bus_b.slv_rdata = {32'h2222_2222, 32'h3333_3333, 32'h0};
    bus_b.slv_ack   = 3'b100;
    for (int k = 1; k <= 3; k++) begin
      check("t5_foreign_req",   32'(bus_b.slv_req),   32'b010);
      check("t5_foreign_stall", 32'(bus_b.lsu_stall), 32'd1);
      step();
    end
    bus_b.slv_ack = 3'b010;
    step();
    bus_b.slv_ack = '0;
    check("t5_done_stall", 32'(bus_b.lsu_stall), 32'd0);
    check("t5_rdata1",     bus_b.lsu_rdata,      32'h3333_3333);
    lsu_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    lsu_b(1'b1, 1'b0, 4'hF, 32'h8000_0104, 32'h0);
    step();
    check("t5_prio_req1", 32'(bus_b.slv_req), 32'b010);
    bus_b.slv_ack = 3'b010;
    step();
    bus_b.slv_ack = '0;
    lsu_b(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();

    // 6: reset mid-BUSY aborts without counting an error
    lsu_a(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    step();
    check("t6_busy_req", 32'(bus_a.slv_req), 32'b001);
    reset = 1'b1;
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 check_a_zero("t6_async");
    step();
    check_a_zero("t6_edge");
    reset = 1'b0;
    step();
    check("t6_no_err", 32'(bus_a.err_cnt), 32'd0);

    // 300 back-to-back unmapped accesses: counter saturates at 255
    lsu_a(1'b1, 1'b0, 4'hF, 32'h4000_0000, 32'h0);
    for (int n = 1; n <= 300; n++) begin
      step();
      check("t6_sat_cnt", 32'(bus_a.err_cnt), (n > 255) ? 32'd255 : 32'(n));
      if (n == 300) check("t6_sat_err", 32'(bus_a.bus_err), 32'd1);
      step();
    end
    lsu_a(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("t6_sat_final", 32'(bus_a.err_cnt), 32'd255);
    check("t6_final_err", 32'(bus_a.bus_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
